// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative radix-2 multiply/divide unit with architectural HI/LO registers.
// Takes WIDTH cycles per operation; HI/LO are written when the result handshake completes.
module mul_div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [2*WIDTH-1:0] acc, acc_step, res;
   logic [WIDTH-1:0] opnd, a_mag, b_mag, r_mag, q_mag;
   logic [WIDTH:0] add_s, rem_sh, sub_s;
   logic is_div, neg_p, neg_r, accept, start, sgn_op, retire, last;

   always_comb begin
      in_ready  = state == IDLE && !flush && !rst;
      out_valid = state == DONE;
      busy      = state != IDLE;
      accept    = in_valid && in_ready;
      start     = accept && !op[2];
      sgn_op    = !op[0];
      retire    = out_valid && out_ready && !flush;
      last      = cnt == CNT_W'(WIDTH - 1);
      a_mag     = sgn_op && src1[WIDTH-1] ? -src1 : src1;
      b_mag     = sgn_op && src2[WIDTH-1] ? -src2 : src2;
      add_s     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
      rem_sh    = acc[2*WIDTH-1:WIDTH-1];
      sub_s     = rem_sh - {1'b0, opnd};
      // Divide: remainder in the upper half, quotient bits shift in from the bottom
      acc_step  = is_div ? (sub_s[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                         : {sub_s[WIDTH-1:0], acc[WIDTH-2:0], 1'b1})
                         : (acc[0] ? {add_s, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]});
      r_mag     = acc[2*WIDTH-1:WIDTH];
      q_mag     = acc[WIDTH-1:0];
      res       = is_div ? {neg_r ? -r_mag : r_mag, neg_p ? -q_mag : q_mag}
                         : (neg_p ? -acc : acc);
      state_nx  = state;
      case (state)
         IDLE:    state_nx = start ? BUSY : IDLE;
         BUSY:    state_nx = flush ? IDLE : (last ? DONE : BUSY);
         DONE:    state_nx = flush || out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         opnd   <= '0;
         is_div <= 1'b0;
         neg_p  <= 1'b0;
         neg_r  <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         state <= state_nx;
         if (start) begin
            acc    <= {{WIDTH{1'b0}}, op[1] ? a_mag : b_mag};
            opnd   <= op[1] ? b_mag : a_mag;
            cnt    <= '0;
            is_div <= op[1];
            // A zero divisor keeps the all-ones quotient un-negated
            neg_p  <= sgn_op && (src1[WIDTH-1] ^ src2[WIDTH-1]) && !(op[1] && src2 == '0);
            neg_r  <= sgn_op && op[1] && src1[WIDTH-1];
         end else if (state == BUSY && !flush) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
         end
         if (accept && op == 3'b100) hi <= src1;
         if (accept && op == 3'b101) lo <= src1;
         if (retire) {hi, lo} <= res;
      end
   end
endmodule
